// File: rtl/imm_gen_pipe.sv
// Decode-stage immediate generator for all RV base formats, with PC-relative target.
// Decoded entries pass through one registered stage backed by a skid buffer, so stalls never drop an instruction.
module imm_gen_pipe #(
    parameter int XLEN      = 32,
    parameter int PC_W      = 32,
    parameter bit EN_TARGET = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [PC_W-1:0] out_target,
    output logic [PC_W-1:0] out_pc,
    output logic            out_illegal
);
    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [PC_W-1:0] target;
        logic [PC_W-1:0] pc;
        logic            illegal;
    } entry_t;

    entry_t          dec, main_q, skid_q;
    logic            main_valid, skid_valid;
    logic            accept, drain;
    logic [PC_W-1:0] imm_pc;

    // Sign extension comes from size-casting a signed field to the wider width.
    always_comb begin
        dec     = '0;
        dec.pc  = in_pc;
        imm_pc  = '0;
        if (in_inst[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            case (in_inst[6:0])
                7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
                    dec.fmt = FMT_I;
                    dec.imm = XLEN'($signed(in_inst[31:20]));
                end
                7'b0011011: begin
                    if (XLEN == 64) begin
                        dec.fmt = FMT_I;
                        dec.imm = XLEN'($signed(in_inst[31:20]));
                    end else begin
                        dec.illegal = 1'b1;
                    end
                end
                7'b0100011: begin
                    dec.fmt = FMT_S;
                    dec.imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
                end
                7'b1100011: begin
                    dec.fmt = FMT_B;
                    dec.imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                             in_inst[11:8], 1'b0}));
                end
                7'b0110111, 7'b0010111: begin
                    dec.fmt = FMT_U;
                    dec.imm = XLEN'($signed({in_inst[31:12], 12'b0}));
                end
                7'b1101111: begin
                    dec.fmt = FMT_J;
                    dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                             in_inst[30:21], 1'b0}));
                end
                7'b0110011: ;
                7'b0111011: dec.illegal = (XLEN != 64);
                default:    dec.illegal = 1'b1;
            endcase
        end
        imm_pc = PC_W'($signed(dec.imm));
        if (EN_TARGET && (dec.fmt == FMT_B || dec.fmt == FMT_J))
            dec.target = in_pc + imm_pc;
    end

    assign in_ready = rst_n & ~skid_valid;
    assign accept   = in_valid & in_ready;
    assign drain    = main_valid & out_ready;

    // Skid only fills while main is held, and in_ready drops once it does,
    // so skid and input can never compete for main in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || drain) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (accept) begin
                main_q     <= dec;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (accept) begin
            skid_q     <= dec;
            skid_valid <= 1'b1;
        end
    end

    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_target  = main_q.target;
    assign out_pc      = main_q.pc;
    assign out_illegal = main_q.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: decode vectors, stall/skid ordering, flush and reset.
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_inst, in_pc, out_imm, out_target, out_pc;
    logic [2:0]  out_fmt;
    int          total = 0;
    int          bad   = 0;

    imm_gen_pipe #(.XLEN(32), .PC_W(32), .EN_TARGET(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm), .out_fmt(out_fmt),
        .out_target(out_target), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
        send(32'hFFF00093, 32'h40);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        step();
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_imm", 64'(out_imm), 64'(0));
        chk("rst_out_fmt", 64'(out_fmt), 64'(0));
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'(1));

        // addi x1,x0,-1
        step();
        chk("addi_valid", 64'(out_valid), 64'(1));
        chk("addi_imm", 64'(out_imm), 64'(32'hFFFFFFFF));
        chk("addi_fmt", 64'(out_fmt), 64'(1));
        chk("addi_illegal", 64'(out_illegal), 64'(0));
        chk("addi_target", 64'(out_target), 64'(0));
        chk("addi_pc", 64'(out_pc), 64'(32'h40));

        send(32'hFE000CE3, 32'h100); // beq -8
        step();
        chk("beq_imm", 64'(out_imm), 64'(32'hFFFFFFF8));
        chk("beq_fmt", 64'(out_fmt), 64'(3));
        chk("beq_target", 64'(out_target), 64'(32'h0F8));

        send(32'h0200006F, 32'hFFFFFFF0); // jal +0x20, wraps
        step();
        chk("jal_imm", 64'(out_imm), 64'(32'h20));
        chk("jal_fmt", 64'(out_fmt), 64'(5));
        chk("jal_target", 64'(out_target), 64'(32'h10));

        send(32'hFE002E23, 32'h200); // sw -4
        step();
        chk("sw_imm", 64'(out_imm), 64'(32'hFFFFFFFC));
        chk("sw_fmt", 64'(out_fmt), 64'(2));
        chk("sw_target", 64'(out_target), 64'(0));

        send(32'h800000B7, 32'h204); // lui 0x80000
        step();
        chk("lui_imm", 64'(out_imm), 64'(32'h80000000));
        chk("lui_fmt", 64'(out_fmt), 64'(4));

        send(32'h00000013, 32'h208); // nop
        step();
        chk("nop_fmt", 64'(out_fmt), 64'(1));
        chk("nop_illegal", 64'(out_illegal), 64'(0));
        chk("nop_imm", 64'(out_imm), 64'(0));

        send(32'h00000000, 32'h20C); // all-zero word
        step();
        chk("zero_fmt", 64'(out_fmt), 64'(0));
        chk("zero_illegal", 64'(out_illegal), 64'(1));

        send(32'h002081B3, 32'h210); // add
        step();
        chk("add_fmt", 64'(out_fmt), 64'(0));
        chk("add_illegal", 64'(out_illegal), 64'(0));
        chk("add_imm", 64'(out_imm), 64'(0));

        in_valid = 1'b0;
        step();
        chk("idle_out_valid", 64'(out_valid), 64'(0));

        // stall: three back-to-back inputs with consumer blocked
        out_ready = 1'b0;
        send(32'h00100093, 32'h300);
        step();
        send(32'h00200093, 32'h304);
        chk("stall_in_ready_2nd", 64'(in_ready), 64'(1));
        step();
        send(32'h00300093, 32'h308);
        chk("stall_in_ready_3rd", 64'(in_ready), 64'(0));
        step();
        chk("stall_hold_valid", 64'(out_valid), 64'(1));
        chk("stall_hold_imm", 64'(out_imm), 64'(1));
        chk("stall_hold_pc", 64'(out_pc), 64'(32'h300));
        out_ready = 1'b1;
        step();
        chk("order_2_imm", 64'(out_imm), 64'(2));
        chk("order_2_in_ready", 64'(in_ready), 64'(1));
        step();
        chk("order_3_imm", 64'(out_imm), 64'(3));
        chk("order_3_pc", 64'(out_pc), 64'(32'h308));
        in_valid = 1'b0;
        step();
        chk("order_end_valid", 64'(out_valid), 64'(0));

        // flush with two held entries; the concurrent input is discarded
        out_ready = 1'b0;
        send(32'h00400093, 32'h400);
        step();
        send(32'h00500093, 32'h404);
        step();
        send(32'h00600093, 32'h408);
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_out_valid", 64'(out_valid), 64'(0));
        chk("flush_in_ready", 64'(in_ready), 64'(1));
        out_ready = 1'b1;
        step();
        chk("flush_nothing_emitted", 64'(out_valid), 64'(0));

        // reset while stalled drops the held entry and clears outputs
        out_ready = 1'b0;
        send(32'hFE000CE3, 32'h500);
        step();
        in_valid = 1'b0;
        chk("pre_rst_valid", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_valid", 64'(out_valid), 64'(0));
        chk("midrst_pc", 64'(out_pc), 64'(0));
        chk("midrst_target", 64'(out_target), 64'(0));
        chk("midrst_illegal_fmt", 64'({out_illegal, out_fmt}), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
